bank_stream_reader: RTL and testbench

Read-side controller for the dual-port 128x128 bank SRAM. It walks a contiguous address range on the SRAM read port and returns the words as a valid/ready stream with a last-word marker. It is the counterpart of the write path. It hides the fixed SRAM read latency behind a small credit-controlled output FIFO, so downstream backpressure never drops a word.

---
 rtl/bank_stream_reader.sv | 174 +++++++++++++++++
 tb/tb_bank_stream_reader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_stream_reader.sv
// bank_stream_reader: walks an SRAM address range and returns the words
// as a valid/ready stream with a last marker.
// Ports: start/base_addr/length request, busy/done status,
//        mem_rd_en/mem_addr/mem_rdata SRAM read port,
//        out_valid/out_ready/out_data/out_last output stream.
module bank_stream_reader #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 7,
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              vsi_clk,
  input  logic              vsi_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;
  localparam logic [ADDR_W:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } stateE;

  stateE state;
  stateE stateNext;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] issueAddr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   issueLeft;
  logic [ADDR_W:0]   wordsLeft;
  logic [LAT-1:0]    pipe;
  logic [DATA_W:0]   fifoMem [FIFO_DEPTH];
  logic [DATA_W:0]   head;
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [CW-1:0]     fifoCount;
  logic [CW-1:0]     used;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              headLast;

  assign head      = fifoMem[rdPtr];
  assign headLast  = head[DATA_W];
  assign out_valid = fifoCount != '0;
  // Gate the head so outputs read 0 whenever the FIFO is empty.
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
  assign out_last  = out_valid & headLast;
  assign pop       = out_valid & out_ready;
  assign push      = pipe[LAT-1];

  assign issueAddr = accept ? base_addr : addr;
  assign issueLeft = accept ? length : remaining;

  // Slots already claimed: buffered words plus reads still in flight
  // (the registered enable stage and the latency shift register).
  always_comb begin
    used = fifoCount + CW'(mem_rd_en);
    for (int i = 0; i < LAT; i++) begin
      used = used + CW'(pipe[i]);
    end
  end

  // The first read goes out on the accepting edge, so the pipeline
  // starts one cycle earlier and a 1-word burst skips ISSUE.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    issue     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept = 1'b1;
          if (length == '0) begin
            stateNext = FIN;
          end else begin
            issue     = 1'b1;
            stateNext = (length == ONE) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (used < CW'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (remaining == ONE) begin
            stateNext = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && headLast) begin
          stateNext = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
    if (!vsi_reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
    if (!vsi_reset_n) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      addr      <= '0;
      remaining <= '0;
      wordsLeft <= '0;
      pipe      <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      mem_rd_en <= issue;
      if (issue) begin
        mem_addr  <= issueAddr;
        addr      <= issueAddr + ADDR_W'(1);
        remaining <= issueLeft - ONE;
      end
      if (accept) begin
        wordsLeft <= length;
      end else if (push) begin
        wordsLeft <= wordsLeft - ONE;
      end
      pipe[0] <= mem_rd_en;
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      fifoCount <= fifoCount + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge vsi_clk) begin
    if (push) begin
      fifoMem[wrPtr] <= {wordsLeft == ONE, mem_rdata};
    end
  end

endmodule

// File: tb/tb_bank_stream_reader.sv
// tb_bank_stream_reader: randomized and directed bursts against a
// queue-based model of the address range and expected beats.
module tb_bank_stream_reader;

  localparam int DW    = 128;
  localparam int AW    = 7;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  bank_stream_reader #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .LAT(LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .vsi_clk(clk),
    .vsi_reset_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  logic [DW-1:0] mem [128];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  int compared = 0;
  int mismatched = 0;

  function automatic void chk(input string nm, input bit ok,
                              input logic [255:0] got,
                              input logic [255:0] exp);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endfunction

  int            addrQ[$];
  logic [DW:0]   beatQ[$];
  bit            busyM = 0;
  bit            doneM = 0;
  bit            prevStall = 0;
  logic [DW-1:0] prevData;
  logic          prevLast;
  int            issued = 0;
  int            popped = 0;
  int            maxOut = 0;
  int            cyc = 0;
  int            busyCnt = 0;
  int            validCnt = 0;
  int            holdCnt = 0;
  int            addrLog[$];
  int            addrCyc[$];
  int            beatCyc[$];
  bit            beatLast[$];
  int            doneCyc[$];
  int            accCyc[$];

  always @(negedge clk) begin
    bit nb;
    bit nd;
    logic [DW:0] e;
    int ad;
    cyc++;
    if (!rst_n) begin
      chk("rstOut", {busy, done, mem_rd_en, mem_addr, out_valid,
                     out_last, out_data} === '0,
          {busy, done, mem_rd_en, out_valid, out_last}, 0);
      addrQ.delete();
      beatQ.delete();
      busyM = 0;
      doneM = 0;
      issued = 0;
      popped = 0;
      prevStall = 0;
    end else begin
      chk("busy", busy === busyM, busy, busyM);
      chk("done", done === doneM, done, doneM);
      if (done) doneCyc.push_back(cyc);
      if (busy) busyCnt++;
      if (out_valid) validCnt++;
      nb = busyM;
      nd = 0;
      if (doneM) nb = 0;
      if (start && !busyM) begin
        accCyc.push_back(cyc);
        for (int i = 0; i < int'(length); i++) begin
          ad = (int'(base_addr) + i) % 128;
          addrQ.push_back(ad);
          beatQ.push_back({i == int'(length) - 1, mem[ad]});
        end
        nb = 1;
        if (length == 0) nd = 1;
      end
      if (mem_rd_en) begin
        addrLog.push_back(int'(mem_addr));
        addrCyc.push_back(cyc);
        issued++;
        if (addrQ.size() == 0) begin
          chk("extraRead", 0, mem_addr, 0);
        end else begin
          ad = addrQ.pop_front();
          chk("addr", int'(mem_addr) == ad, mem_addr, ad);
        end
        if (issued - popped > maxOut) maxOut = issued - popped;
        chk("credit", issued - popped <= DEPTH, issued - popped, DEPTH);
      end
      if (prevStall) begin
        holdCnt++;
        chk("hold", out_valid && out_data === prevData &&
            out_last === prevLast, {out_valid, out_last, out_data},
            {1'b1, prevLast, prevData});
      end
      if (out_valid && out_ready) begin
        popped++;
        beatCyc.push_back(cyc);
        beatLast.push_back(out_last);
        if (beatQ.size() == 0) begin
          chk("extraBeat", 0, {out_last, out_data}, 0);
        end else begin
          e = beatQ.pop_front();
          chk("beat", {out_last, out_data} === e, {out_last, out_data}, e);
          if (e[DW]) nd = 1;
        end
      end
      prevStall = out_valid && !out_ready;
      prevData = out_data;
      prevLast = out_last;
      busyM = nb;
      doneM = nd;
    end
  end

  int readyMode = 0;
  int rph = 0;

  always @(posedge clk) begin
    #1;
    rph = (rph + 1) % 3;
    case (readyMode)
      1: out_ready = (rph == 0);
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  task automatic doStart(input int b, input int l);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b);
    length = (AW+1)'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int d0, input int budget);
    int n = 0;
    while (doneCyc.size() == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (doneCyc.size() == d0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("drained", addrQ.size() == 0 && beatQ.size() == 0,
        addrQ.size() + beatQ.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, b0, d0, v0, acc0, bz0, hc0, l, n;
    int wrapExp[4];
    wrapExp = '{126, 127, 0, 1};
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    a0 = addrLog.size(); b0 = beatCyc.size(); d0 = doneCyc.size();
    doStart(5, 4);
    waitDone(d0, 200);
    for (int k = 0; k < 4; k++) begin
      chk("basicAddr", addrLog.size() > a0 + k &&
          addrLog[a0+k] == 5 + k && addrCyc[a0+k] == addrCyc[a0] + k,
          addrLog[a0+k], 5 + k);
      chk("basicLast", beatLast[b0+k] == (k == 3), beatLast[b0+k], k == 3);
    end
    chk("basicBeats", beatCyc.size() - b0 == 4 &&
        beatCyc[b0+3] - beatCyc[b0] == 3, beatCyc.size() - b0, 4);
    chk("firstLat", beatCyc[b0] - addrCyc[a0] == LAT + 1,
        beatCyc[b0] - addrCyc[a0], LAT + 1);
    chk("doneOnce", doneCyc.size() - d0 == 1 &&
        doneCyc[d0] == beatCyc[b0+3] + 1, doneCyc[d0], beatCyc[b0+3] + 1);

    a0 = addrLog.size(); b0 = beatCyc.size(); d0 = doneCyc.size();
    doStart(126, 4);
    waitDone(d0, 200);
    for (int k = 0; k < 4; k++) begin
      chk("wrapAddr", addrLog[a0+k] == wrapExp[k], addrLog[a0+k], wrapExp[k]);
    end
    chk("wrapBeats", beatCyc.size() - b0 == 4 && beatLast[b0+3] &&
        !beatLast[b0+2], beatCyc.size() - b0, 4);

    readyMode = 1;
    b0 = beatCyc.size(); d0 = doneCyc.size(); hc0 = holdCnt;
    doStart(0, 16);
    waitDone(d0, 600);
    readyMode = 0;
    chk("bpBeats", beatCyc.size() - b0 == 16, beatCyc.size() - b0, 16);
    chk("bpDepth", maxOut == DEPTH, maxOut, DEPTH);
    chk("bpHold", holdCnt > hc0, holdCnt - hc0, 1);

    a0 = addrLog.size(); d0 = doneCyc.size();
    v0 = validCnt; acc0 = accCyc.size();
    doStart(0, 0);
    waitDone(d0, 20);
    chk("zeroRead", addrLog.size() == a0, addrLog.size() - a0, 0);
    chk("zeroValid", validCnt == v0, validCnt - v0, 0);
    chk("zeroDone", doneCyc.size() - d0 == 1 &&
        doneCyc[d0] - accCyc[acc0] == 1, doneCyc[d0] - accCyc[acc0], 1);

    b0 = beatCyc.size(); d0 = doneCyc.size(); acc0 = accCyc.size();
    doStart(10, 10);
    repeat (2) @(posedge clk);
    doStart(50, 5);
    waitDone(d0, 300);
    chk("busyStartAcc", accCyc.size() - acc0 == 1, accCyc.size() - acc0, 1);
    chk("busyStartBeats", beatCyc.size() - b0 == 10,
        beatCyc.size() - b0, 10);
    chk("busyStartDone", doneCyc.size() - d0 == 1, doneCyc.size() - d0, 1);

    a0 = addrLog.size(); b0 = beatCyc.size();
    d0 = doneCyc.size(); bz0 = busyCnt;
    doStart(64, 128);
    waitDone(d0, 1000);
    chk("fullBusy", busyCnt - bz0 == 128 + LAT + 2,
        busyCnt - bz0, 128 + LAT + 2);
    chk("fullBeats", beatCyc.size() - b0 == 128, beatCyc.size() - b0, 128);
    chk("fullA0", addrLog[a0] == 64, addrLog[a0], 64);
    chk("fullA63", addrLog[a0+63] == 127, addrLog[a0+63], 127);
    chk("fullA64", addrLog[a0+64] == 0, addrLog[a0+64], 0);
    chk("fullA127", addrLog[a0+127] == 63, addrLog[a0+127], 63);

    b0 = beatCyc.size(); d0 = doneCyc.size();
    doStart(0, 8);
    n = 0;
    while (beatCyc.size() - b0 < 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rstReach", beatCyc.size() - b0 >= 3, beatCyc.size() - b0, 3);
    rst_n = 1'b0;
    #1;
    chk("rstNow", {busy, done, mem_rd_en, mem_addr, out_valid,
                   out_last, out_data} === '0,
        {busy, done, mem_rd_en, out_valid, out_last}, 0);
    repeat (3) @(negedge clk);
    #2;
    chk("rstNoDone", doneCyc.size() == d0, doneCyc.size() - d0, 0);
    rst_n = 1'b1;
    a0 = addrLog.size(); b0 = beatCyc.size(); d0 = doneCyc.size();
    doStart(20, 5);
    waitDone(d0, 200);
    chk("postRstBeats", beatCyc.size() - b0 == 5, beatCyc.size() - b0, 5);
    chk("postRstAddr", addrLog[a0] == 20, addrLog[a0], 20);

    for (int r = 0; r < 12; r++) begin
      readyMode = $urandom_range(0, 2);
      l = $urandom_range(1, 40);
      b0 = beatCyc.size(); d0 = doneCyc.size();
      doStart($urandom_range(0, 127), l);
      waitDone(d0, 2000);
      chk("randBeats", beatCyc.size() - b0 == l, beatCyc.size() - b0, l);
    end
    readyMode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
